// File: rtl/sort_cmd_sequencer.sv
// Decodes SPI frames into LOAD / READ / CLEAR and drives the sorter strobes; tracks occupancy.
// Latency: every sorter strobe is registered, 1 cycle after its rx_valid (or after CLEAR entry).
// Backpressure: none; rx_valid is a pulse, and frames arriving during CLEAR are dropped with cmd_error.
module sort_cmd_sequencer #(
    parameter  int DATA_WIDTH = 8,
    parameter  int SIZE       = 10,
    localparam int CNT_W      = $clog2(SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  cs_n,
    output logic                  sort_enable,
    output logic                  sort_write,
    output logic [DATA_WIDTH-1:0] sort_data,
    output logic [CNT_W-1:0]      fill_count,
    output logic                  busy,
    output logic                  overflow,
    output logic                  cmd_error
);

    localparam logic [7:0]       OP_LOAD  = 8'hA1;
    localparam logic [7:0]       OP_READ  = 8'hA2;
    localparam logic [7:0]       OP_CLEAR = 8'hA3;
    localparam logic [CNT_W-1:0] SIZE_C   = CNT_W'(SIZE);
    localparam logic [CNT_W-1:0] SIZE_M1  = CNT_W'(SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_LOAD,
        S_READ,
        S_CLEAR
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        remaining, remaining_nxt;
    logic [CNT_W-1:0]        clr_cnt, clr_cnt_nxt;
    logic [CNT_W-1:0]        fill_nxt;
    logic [CNT_W-1:0]        len_raw, len_clamped;
    logic                    en_nxt, wr_nxt, err_nxt, ovf_nxt;
    logic [DATA_WIDTH-1:0]   data_nxt;
    logic [7:0]              opcode;

    assign opcode      = rx_data[7:0];
    assign len_raw     = rx_data[CNT_W-1:0];
    assign len_clamped = (len_raw > SIZE_C) ? SIZE_C : len_raw;

    // State register; busy is registered alongside so it tracks the state exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
        end
    end

    // Next-state logic. A byte that arrives with cs_n high is handled first, then IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    case (opcode)
                        OP_LOAD:  state_nxt = S_LEN;
                        OP_READ:  state_nxt = S_READ;
                        OP_CLEAR: state_nxt = S_CLEAR;
                        default:  state_nxt = S_IDLE;
                    endcase
                end
            end
            S_LEN: begin
                if (rx_valid) state_nxt = (len_clamped == '0) ? S_IDLE : S_LOAD;
                if (cs_n)     state_nxt = S_IDLE;
            end
            S_LOAD: begin
                if (rx_valid && remaining == CNT_W'(1)) state_nxt = S_IDLE;
                if (cs_n)                               state_nxt = S_IDLE;
            end
            S_READ: begin
                if (cs_n) state_nxt = S_IDLE;
            end
            S_CLEAR: begin
                if (clr_cnt == SIZE_M1) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values; all of them are registered below.
    always_comb begin
        en_nxt        = 1'b0;
        wr_nxt        = 1'b0;
        data_nxt      = sort_data;
        err_nxt       = 1'b0;
        fill_nxt      = fill_count;
        ovf_nxt       = overflow;
        remaining_nxt = remaining;
        clr_cnt_nxt   = '0;
        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    case (opcode)
                        OP_LOAD, OP_CLEAR: ;
                        OP_READ: begin
                            if (fill_count != '0) begin
                                en_nxt   = 1'b1;
                                fill_nxt = fill_count - 1'b1;
                            end
                        end
                        default: err_nxt = 1'b1;
                    endcase
                end
            end
            S_LEN: begin
                if (rx_valid) remaining_nxt = len_clamped;
            end
            S_LOAD: begin
                if (rx_valid) begin
                    if (fill_count < SIZE_C) begin
                        en_nxt   = 1'b1;
                        wr_nxt   = 1'b1;
                        data_nxt = rx_data;
                        fill_nxt = fill_count + 1'b1;
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                    remaining_nxt = remaining - 1'b1;
                end
            end
            S_READ: begin
                if (rx_valid && fill_count != '0) begin
                    en_nxt   = 1'b1;
                    fill_nxt = fill_count - 1'b1;
                end
            end
            S_CLEAR: begin
                // Pops are issued blindly so the sorter is drained even if our count drifted.
                en_nxt      = 1'b1;
                clr_cnt_nxt = clr_cnt + 1'b1;
                err_nxt     = rx_valid;
                if (clr_cnt == SIZE_M1) begin
                    fill_nxt = '0;
                    ovf_nxt  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sort_enable <= 1'b0;
            sort_write  <= 1'b0;
            sort_data   <= '0;
            fill_count  <= '0;
            overflow    <= 1'b0;
            cmd_error   <= 1'b0;
            remaining   <= '0;
            clr_cnt     <= '0;
        end else begin
            sort_enable <= en_nxt;
            sort_write  <= wr_nxt;
            sort_data   <= data_nxt;
            fill_count  <= fill_nxt;
            overflow    <= ovf_nxt;
            cmd_error   <= err_nxt;
            remaining   <= remaining_nxt;
            clr_cnt     <= clr_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_sort_cmd_sequencer.sv
// Bench for sort_cmd_sequencer: directed scenarios plus random transactions, scoreboarded
// against a frame-level model of the command protocol.
module tb_sort_cmd_sequencer;

    localparam int DW    = 8;
    localparam int SIZE  = 10;
    localparam int CNT_W = $clog2(SIZE + 1);

    logic             clk = 1'b0;
    logic             reset_n;
    logic             rx_valid;
    logic [DW-1:0]    rx_data;
    logic             cs_n;
    logic             sort_enable, sort_write, busy, overflow, cmd_error;
    logic [DW-1:0]    sort_data;
    logic [CNT_W-1:0] fill_count;

    sort_cmd_sequencer #(.DATA_WIDTH(DW), .SIZE(SIZE)) dut (
        .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data), .cs_n(cs_n),
        .sort_enable(sort_enable), .sort_write(sort_write), .sort_data(sort_data),
        .fill_count(fill_count), .busy(busy), .overflow(overflow), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          wr;
        logic [DW-1:0] dat;
        logic          clr;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_err = 0;

    // Frame-level model: which command we are in, bytes still owed, occupancy, sticky overflow.
    localparam int M_IDLE = 0, M_LEN = 1, M_LOAD = 2, M_READ = 3;
    int m_mode = M_IDLE;
    int m_rem  = 0;
    int m_fill = 0;
    bit m_ovf  = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_pop();
        if (m_fill > 0) begin
            exp_q.push_back('{wr: 1'b0, dat: '0, clr: 1'b0});
            m_fill--;
        end
    endfunction

    function automatic void model_frame(input logic [7:0] b, input bit cs_hi);
        int r;
        case (m_mode)
            M_IDLE: begin
                if (b == 8'hA1) m_mode = M_LEN;
                else if (b == 8'hA2) begin
                    model_pop();
                    m_mode = M_READ;
                end else if (b == 8'hA3) begin
                    for (int i = 0; i < SIZE; i++) exp_q.push_back('{wr: 1'b0, dat: '0, clr: 1'b1});
                    m_fill = 0;
                    m_ovf  = 1'b0;
                end else exp_err++;
            end
            M_LEN: begin
                r = int'(b) % (1 << CNT_W);
                if (r > SIZE) r = SIZE;
                m_rem  = r;
                m_mode = (r == 0) ? M_IDLE : M_LOAD;
            end
            M_LOAD: begin
                if (m_fill < SIZE) begin
                    exp_q.push_back('{wr: 1'b1, dat: b, clr: 1'b0});
                    m_fill++;
                end else m_ovf = 1'b1;
                m_rem--;
                if (m_rem == 0) m_mode = M_IDLE;
            end
            default: model_pop();
        endcase
        if (cs_hi) m_mode = M_IDLE;
    endfunction

    // Monitor: every strobe and error pulse must match an expectation queued by the model.
    exp_t mon_e;
    bit   prev_rx = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (sort_enable) begin
                chk("strobe_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("strobe_write", sort_write, mon_e.wr);
                    if (mon_e.wr) chk("push_data", sort_data, mon_e.dat);
                    if (!mon_e.clr) chk("strobe_latency", prev_rx, 1);
                end
            end
            if (cmd_error) begin
                chk("cmd_error_expected", int'(exp_err > 0), 1);
                if (exp_err > 0) exp_err--;
            end
        end
        prev_rx = rx_valid;
    end

    task automatic send(input logic [7:0] b, input bit cs_hi);
        model_frame(b, cs_hi);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        if (cs_hi) cs_n = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
    endtask

    task automatic cs_low();
        @(posedge clk); #1;
        cs_n = 1'b0;
    endtask

    task automatic cs_release();
        @(posedge clk); #1;
        cs_n   = 1'b1;
        m_mode = M_IDLE;
    endtask

    task automatic check_idle(input string tag);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_fill"}, fill_count, m_fill);
        chk({tag, "_overflow"}, overflow, m_ovf);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pending_strobes"}, exp_q.size(), 0);
        chk({tag, "_pending_errors"}, exp_err, 0);
    endtask

    task automatic clear_cmd(input bit inject);
        send(8'hA3, 1'b0);
        if (inject) begin
            exp_err++;
            @(posedge clk); #1;
            rx_valid = 1'b1;
            rx_data  = 8'hA1;
            @(posedge clk); #1;
            rx_valid = 1'b0;
        end
        repeat (SIZE + 4) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        int         op, n, r, k;
        bit         lc;

        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        cs_n     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({sort_enable, sort_write, sort_data, fill_count, busy, overflow, cmd_error}), 0);
        reset_n = 1'b1;

        // Three pushes.
        cs_low();
        send(8'hA1, 0); send(8'h03, 0); send(8'h07, 0); send(8'h02, 0); send(8'h09, 0);
        cs_release();
        check_idle("load3");

        // Read with one suppressed pop; busy while in READ.
        cs_low();
        send(8'hA2, 0);
        chk("read_busy", busy, 1);
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        cs_release();
        check_idle("read4");

        // Overflow: preload 2, then a clamped length of 10.
        cs_low();
        send(8'hA1, 0); send(8'h02, 0); send(8'h5A, 0); send(8'hC3, 0);
        send(8'hA1, 0); send(8'h0C, 0);
        for (int i = 0; i < 10; i++) send(8'(8'h30 + i), 0);
        cs_release();
        check_idle("overflow");

        // Clear with a frame injected mid-sequence.
        cs_low();
        clear_cmd(1'b1);
        cs_release();
        check_idle("clear");

        // Bad opcode, then a load abandoned by cs_n.
        cs_low();
        send(8'h55, 0);
        send(8'hA1, 0); send(8'h05, 0); send(8'h11, 0);
        cs_release();
        check_idle("bad_op_partial");

        // Asynchronous reset in the middle of a load.
        cs_low();
        send(8'hA1, 0); send(8'h05, 0); send(8'h22, 0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({sort_enable, sort_write, sort_data, fill_count, busy, overflow, cmd_error}), 0);
        m_fill = 0; m_ovf = 1'b0; m_mode = M_IDLE;
        exp_q.delete();
        cs_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cs_low();
        send(8'hA2, 0);
        cs_release();
        check_idle("post_reset_read");

        // Random transactions.
        for (int t = 0; t < 40; t++) begin
            op = $urandom_range(0, 3);
            lc = 1'($urandom_range(0, 1));
            cs_low();
            case (op)
                0: begin
                    v = 8'($urandom_range(0, 255));
                    r = int'(v) % (1 << CNT_W);
                    if (r > SIZE) r = SIZE;
                    n = ($urandom_range(0, 1) == 1) ? r : $urandom_range(0, r);
                    send(8'hA1, 0);
                    send(v, lc && n == 0);
                    for (int i = 0; i < n; i++) send(8'($urandom_range(0, 255)), lc && i == n - 1);
                end
                1: begin
                    k = $urandom_range(0, 5);
                    send(8'hA2, lc && k == 0);
                    for (int i = 0; i < k; i++) send(8'h00, lc && i == k - 1);
                end
                2: clear_cmd(1'($urandom_range(0, 1)));
                default: begin
                    do v = 8'($urandom_range(0, 255)); while (v == 8'hA1 || v == 8'hA2 || v == 8'hA3);
                    send(v, 0);
                end
            endcase
            cs_release();
            check_idle("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
